proc_ctrl: RTL and testbench

Control unit for the 16-bit bus-based datapath: fetches an instruction word from the data input, decodes it, and drives the datapath's register enables, tri-state bus enables, ALU op, and PC advance one cycle at a time. It sits beside the datapath and shares its clock. All datapath control inputs come only from this block, and `done` reports instruction completion to the top level.

---
 rtl/proc_ctrl_pkg.sv | 46 ++++
 rtl/reg_sel_dec.sv | 20 ++
 rtl/proc_ctrl.sv | 143 ++++++++++++++
 tb/tb_proc_ctrl.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/proc_ctrl_pkg.sv
// rtl/proc_ctrl_pkg.sv - shared types and constants for the proc_ctrl control unit
package proc_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_T1    = 3'd2,
        S_T2    = 3'd3,
        S_T3    = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    localparam logic [2:0] OPC_MV  = 3'b000;
    localparam logic [2:0] OPC_MVI = 3'b001;
    localparam logic [2:0] OPC_ADD = 3'b010;
    localparam logic [2:0] OPC_SUB = 3'b011;
    localparam logic [2:0] OPC_AND = 3'b100;
    localparam logic [2:0] OPC_OR  = 3'b101;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_OR  = 2'b11;

    localparam int OPC_MSB = 15;
    localparam int OPC_LSB = 13;
    localparam int RX_MSB  = 12;
    localparam int RX_LSB  = 10;
    localparam int RY_MSB  = 9;
    localparam int RY_LSB  = 7;

    function automatic logic [1:0] alu_op_of(input logic [2:0] opc);
        case (opc)
            OPC_SUB: alu_op_of = ALU_SUB;
            OPC_AND: alu_op_of = ALU_AND;
            OPC_OR:  alu_op_of = ALU_OR;
            default: alu_op_of = ALU_ADD;
        endcase
    endfunction

    function automatic logic is_alu_opc(input logic [2:0] opc);
        is_alu_opc = (opc == OPC_ADD) || (opc == OPC_SUB) ||
                     (opc == OPC_AND) || (opc == OPC_OR);
    endfunction

endpackage

// File: rtl/reg_sel_dec.sv
// rtl/reg_sel_dec.sv - one-hot register drive/load decoder into the 16-bit reg_sig layout
module reg_sel_dec (
    input  logic [2:0]  i_idx,
    input  logic        i_drive,
    input  logic        i_load,
    output logic [15:0] o_reg_sig
);

    // Rk load sits at bit 15-2k, Rk drive at bit 14-2k
    always_comb begin
        o_reg_sig = '0;
        for (int k = 0; k < 8; k++) begin
            if (i_idx == 3'(k)) begin
                o_reg_sig[14-2*k] = i_drive;
                o_reg_sig[15-2*k] = i_load;
            end
        end
    end

endmodule

// File: rtl/proc_ctrl.sv
// rtl/proc_ctrl.sv - multi-cycle control unit sequencing the 16-bit bus datapath
module proc_ctrl
    import proc_ctrl_pkg::*;
#(
    parameter int IW = 16
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          run,
    input  logic [IW-1:0] instr,
    output logic [15:0]   reg_sig,
    output logic          data_in,
    output logic          A_in,
    output logic          G_in,
    output logic          G_out,
    output logic [1:0]    op,
    output logic          pc_enabled,
    output logic          busy,
    output logic          done,
    output logic          err
);

    state_t          r_state;
    state_t          w_next;
    logic [IW-1:0]   r_ir;

    logic [2:0]      w_opc;
    logic [2:0]      w_rx;
    logic [2:0]      w_ry;
    logic            w_unused_ir;

    logic [2:0]      w_drv_idx;
    logic            w_drv_en;
    logic [2:0]      w_ld_idx;
    logic            w_ld_en;
    logic [15:0]     w_drv_sig;
    logic [15:0]     w_ld_sig;

    assign w_opc       = r_ir[OPC_MSB:OPC_LSB];
    assign w_rx        = r_ir[RX_MSB:RX_LSB];
    assign w_ry        = r_ir[RY_MSB:RY_LSB];
    assign w_unused_ir = ^r_ir[6:0];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= S_IDLE;
            r_ir    <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == S_FETCH) begin
                r_ir <= instr;
            end
        end
    end

    always_comb begin
        w_next     = r_state;
        w_drv_idx  = 3'd0;
        w_drv_en   = 1'b0;
        w_ld_idx   = 3'd0;
        w_ld_en    = 1'b0;
        data_in    = 1'b0;
        A_in       = 1'b0;
        G_in       = 1'b0;
        G_out      = 1'b0;
        op         = ALU_ADD;
        pc_enabled = 1'b0;
        done       = 1'b0;
        err        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (run) w_next = S_FETCH;
            end
            S_FETCH: begin
                pc_enabled = 1'b1;
                w_next     = S_T1;
            end
            S_T1: begin
                w_next = S_DONE;
                if (w_opc == OPC_MV) begin
                    w_drv_idx = w_ry;
                    w_drv_en  = 1'b1;
                    w_ld_idx  = w_rx;
                    w_ld_en   = 1'b1;
                    done      = 1'b1;
                end else if (w_opc == OPC_MVI) begin
                    // Immediate word is on instr now; stepping PC skips past it
                    data_in    = 1'b1;
                    w_ld_idx   = w_rx;
                    w_ld_en    = 1'b1;
                    pc_enabled = 1'b1;
                    done       = 1'b1;
                end else if (is_alu_opc(w_opc)) begin
                    w_drv_idx = w_rx;
                    w_drv_en  = 1'b1;
                    A_in      = 1'b1;
                    w_next    = S_T2;
                end else begin
                    done = 1'b1;
                    err  = 1'b1;
                end
            end
            S_T2: begin
                w_drv_idx = w_ry;
                w_drv_en  = 1'b1;
                G_in      = 1'b1;
                op        = alu_op_of(w_opc);
                w_next    = S_T3;
            end
            S_T3: begin
                G_out    = 1'b1;
                w_ld_idx = w_rx;
                w_ld_en  = 1'b1;
                done     = 1'b1;
                w_next   = S_DONE;
            end
            S_DONE: begin
                w_next = run ? S_FETCH : S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    reg_sel_dec u_drv_dec (
        .i_idx     (w_drv_idx),
        .i_drive   (w_drv_en),
        .i_load    (1'b0),
        .o_reg_sig (w_drv_sig)
    );

    reg_sel_dec u_ld_dec (
        .i_idx     (w_ld_idx),
        .i_drive   (1'b0),
        .i_load    (w_ld_en),
        .o_reg_sig (w_ld_sig)
    );

    assign reg_sig = w_drv_sig | w_ld_sig;
    assign busy    = (r_state != S_IDLE);

endmodule

// File: tb/tb_proc_ctrl.sv
// tb/tb_proc_ctrl.sv - scoreboard bench for proc_ctrl with directed instruction vectors
module tb_proc_ctrl;

    logic        clk = 1'b0;
    logic        resetn;
    logic        run;
    logic [15:0] instr;
    logic [15:0] reg_sig;
    logic        data_in, A_in, G_in, G_out;
    logic [1:0]  op;
    logic        pc_enabled, busy, done, err;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [25:0] v;
        string       nm;
    } exp_t;

    exp_t sb_q[$];

    always #5 clk = ~clk;

    proc_ctrl #(.IW(16)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .run        (run),
        .instr      (instr),
        .reg_sig    (reg_sig),
        .data_in    (data_in),
        .A_in       (A_in),
        .G_in       (G_in),
        .G_out      (G_out),
        .op         (op),
        .pc_enabled (pc_enabled),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    function automatic logic [25:0] ev(input logic [15:0] rs, input logic din, input logic ain,
                                       input logic gin, input logic gout, input logic [1:0] o,
                                       input logic pc, input logic bz, input logic dn,
                                       input logic er);
        ev = {rs, din, ain, gin, gout, o, pc, bz, dn, er};
    endfunction

    localparam logic [25:0] ZERO = 26'd0;

    // Drive inputs for the cycle after the next rising edge and record what that cycle must show
    task automatic cyc(input logic r, input logic [15:0] ins, input logic rn,
                       input logic [25:0] e, input string nm);
        exp_t x;
        @(posedge clk);
        #1;
        run    = r;
        instr  = ins;
        resetn = rn;
        x.v    = e;
        x.nm   = nm;
        sb_q.push_back(x);
    endtask

    task automatic start(input logic [15:0] ins, input string nm);
        cyc(1'b1, 16'h0000, 1'b1, ZERO, {nm, "_idle_run"});
        cyc(1'b0, ins, 1'b1, ev(16'h0, 0, 0, 0, 0, 2'b00, 1, 1, 0, 0), {nm, "_fetch"});
    endtask

    task automatic finish_instr(input string nm);
        cyc(1'b0, 16'h0000, 1'b1, ev(16'h0, 0, 0, 0, 0, 2'b00, 0, 1, 0, 0), {nm, "_done"});
        cyc(1'b0, 16'h0000, 1'b1, ZERO, {nm, "_back_idle"});
    endtask

    // Monitor: compare every cycle that has an outstanding expectation
    initial begin
        exp_t        x;
        logic [25:0] act;
        int          drv_cnt, ld_cnt;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                x   = sb_q.pop_front();
                act = {reg_sig, data_in, A_in, G_in, G_out, op, pc_enabled, busy, done, err};
                n_checks++;
                if (act !== x.v) begin
                    n_fail++;
                    $display("FAIL %s: got reg_sig=%h din=%b ain=%b gin=%b gout=%b op=%b pc=%b busy=%b done=%b err=%b expected vector %h actual vector %h",
                             x.nm, reg_sig, data_in, A_in, G_in, G_out, op, pc_enabled,
                             busy, done, err, x.v, act);
                end
                drv_cnt = int'(data_in) + int'(G_out);
                ld_cnt  = 0;
                for (int k = 0; k < 8; k++) begin
                    drv_cnt += int'(reg_sig[14-2*k]);
                    ld_cnt  += int'(reg_sig[15-2*k]);
                end
                n_checks++;
                if (drv_cnt > 1 || ld_cnt > 1) begin
                    n_fail++;
                    $display("FAIL bus_excl %s: drivers=%0d loads=%0d, required at most 1 each",
                             x.nm, drv_cnt, ld_cnt);
                end
            end
        end
    end

    initial begin
        resetn = 1'b0;
        run    = 1'b0;
        instr  = 16'h0000;

        cyc(1'b0, 16'h0000, 1'b0, ZERO, "reset_a");
        cyc(1'b0, 16'h0000, 1'b0, ZERO, "reset_b");
        cyc(1'b0, 16'h0000, 1'b1, ZERO, "idle");

        // mvi R2, 0x00A5
        start(16'h2800, "mvi");
        cyc(1'b0, 16'h00A5, 1'b1, ev(16'h0800, 1, 0, 0, 0, 2'b00, 1, 1, 1, 0), "mvi_t1");
        finish_instr("mvi");

        // mv R5 <- R1
        start(16'h1480, "mv");
        cyc(1'b0, 16'h0000, 1'b1, ev(16'h1020, 0, 0, 0, 0, 2'b00, 0, 1, 1, 0), "mv_t1");
        finish_instr("mv");

        // sub R3, R6
        start(16'h6F00, "sub");
        cyc(1'b0, 16'h0000, 1'b1, ev(16'h0100, 0, 1, 0, 0, 2'b00, 0, 1, 0, 0), "sub_t1");
        cyc(1'b0, 16'h0000, 1'b1, ev(16'h0004, 0, 0, 1, 0, 2'b01, 0, 1, 0, 0), "sub_t2");
        cyc(1'b0, 16'h0000, 1'b1, ev(16'h0200, 0, 0, 0, 1, 2'b00, 0, 1, 1, 0), "sub_t3");
        finish_instr("sub");

        // illegal opcode 111
        start(16'hE000, "ill");
        cyc(1'b0, 16'h0000, 1'b1, ev(16'h0000, 0, 0, 0, 0, 2'b00, 0, 1, 1, 1), "ill_t1");
        finish_instr("ill");

        // add R3, R3 (rx == ry)
        start(16'h4D80, "add33");
        cyc(1'b0, 16'h0000, 1'b1, ev(16'h0100, 0, 1, 0, 0, 2'b00, 0, 1, 0, 0), "add33_t1");
        cyc(1'b0, 16'h0000, 1'b1, ev(16'h0100, 0, 0, 1, 0, 2'b00, 0, 1, 0, 0), "add33_t2");
        cyc(1'b0, 16'h0000, 1'b1, ev(16'h0200, 0, 0, 0, 1, 2'b00, 0, 1, 1, 0), "add33_t3");
        finish_instr("add33");

        // back-to-back: add R1,R2 then or R4,R7 with run held high
        cyc(1'b1, 16'h0000, 1'b1, ZERO, "b2b_idle_run");
        cyc(1'b1, 16'h4500, 1'b1, ev(16'h0000, 0, 0, 0, 0, 2'b00, 1, 1, 0, 0), "b2b_add_fetch");
        cyc(1'b1, 16'h0000, 1'b1, ev(16'h1000, 0, 1, 0, 0, 2'b00, 0, 1, 0, 0), "b2b_add_t1");
        cyc(1'b1, 16'h0000, 1'b1, ev(16'h0400, 0, 0, 1, 0, 2'b00, 0, 1, 0, 0), "b2b_add_t2");
        cyc(1'b1, 16'h0000, 1'b1, ev(16'h2000, 0, 0, 0, 1, 2'b00, 0, 1, 1, 0), "b2b_add_t3");
        cyc(1'b1, 16'h0000, 1'b1, ev(16'h0000, 0, 0, 0, 0, 2'b00, 0, 1, 0, 0), "b2b_add_done");
        cyc(1'b1, 16'hB380, 1'b1, ev(16'h0000, 0, 0, 0, 0, 2'b00, 1, 1, 0, 0), "b2b_or_fetch");
        cyc(1'b1, 16'h0000, 1'b1, ev(16'h0040, 0, 1, 0, 0, 2'b00, 0, 1, 0, 0), "b2b_or_t1");
        cyc(1'b1, 16'h0000, 1'b1, ev(16'h0001, 0, 0, 1, 0, 2'b11, 0, 1, 0, 0), "b2b_or_t2");
        cyc(1'b0, 16'h0000, 1'b1, ev(16'h0080, 0, 0, 0, 1, 2'b00, 0, 1, 1, 0), "b2b_or_t3");
        finish_instr("b2b_or");

        // reset asserted while add R3,R3 sits in T2
        start(16'h4D80, "rst");
        cyc(1'b0, 16'h0000, 1'b1, ev(16'h0100, 0, 1, 0, 0, 2'b00, 0, 1, 0, 0), "rst_t1");
        cyc(1'b0, 16'h0000, 1'b0, ZERO, "rst_in_t2");
        cyc(1'b0, 16'h0000, 1'b0, ZERO, "rst_hold");
        cyc(1'b0, 16'h0000, 1'b1, ZERO, "rst_release_idle");
        start(16'h1480, "post_rst");
        cyc(1'b0, 16'h0000, 1'b1, ev(16'h1020, 0, 0, 0, 0, 2'b00, 0, 1, 1, 0), "post_rst_t1");
        finish_instr("post_rst");

        @(negedge clk);
        @(negedge clk);
        #1;
        n_checks++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left unchecked, required 0", sb_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
